// File: rtl/reg_bank_access_arbiter.sv
// Arbitrates two requesters (control FSM on A, debug/scan on B) onto the single-bus 8x16 register bank.
// Optional REGBANK_ARB_R0_PROTECT_EN: port-B writes to register 0 are rejected with b_err.
module reg_bank_access_arbiter #(
  parameter int unsigned DW     = 16,
  parameter int unsigned AW     = 3,
  parameter int unsigned A_PRIO = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic [DW-1:0] a_rdata,
  output logic          a_done,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic [DW-1:0] b_rdata,
  output logic          b_done,
  output logic          b_err,
  output logic [DW-1:0] bank_z,
  output logic [AW-1:0] bank_reg_no,
  output logic          bank_ld,
  output logic          bank_t,
  input  logic [DW-1:0] bank_x,
  output logic          busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_XFER = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   rr_q, rr_d;       // 0: A wins a tie, 1: B wins a tie
  logic   we_q, we_d;
  logic   port_q, port_d;   // 0: A owns the access, 1: B

  logic [DW-1:0] bank_z_d, a_rdata_d, b_rdata_d;
  logic [AW-1:0] bank_reg_no_d;
  logic          bank_ld_d, bank_t_d, a_done_d, b_done_d, busy_d;
  logic          grant_b, sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
`ifdef REGBANK_ARB_R0_PROTECT_EN
  logic          b_err_d;
`endif

  // State and registered outputs; bank_reg_no/bank_z double as the latched addr/wdata
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      rr_q        <= 1'b0;
      we_q        <= 1'b0;
      port_q      <= 1'b0;
      bank_z      <= '0;
      bank_reg_no <= '0;
      bank_ld     <= 1'b0;
      bank_t      <= 1'b0;
      a_rdata     <= '0;
      b_rdata     <= '0;
      a_done      <= 1'b0;
      b_done      <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      we_q        <= we_d;
      port_q      <= port_d;
      bank_z      <= bank_z_d;
      bank_reg_no <= bank_reg_no_d;
      bank_ld     <= bank_ld_d;
      bank_t      <= bank_t_d;
      a_rdata     <= a_rdata_d;
      b_rdata     <= b_rdata_d;
      a_done      <= a_done_d;
      b_done      <= b_done_d;
      busy        <= busy_d;
    end
  end

`ifdef REGBANK_ARB_R0_PROTECT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) b_err <= 1'b0;
    else        b_err <= b_err_d;
  end
`else
  assign b_err = 1'b0;
`endif

  // Next state, arbitration and next output values
  always_comb begin
    state_d       = state_q;
    rr_d          = rr_q;
    we_d          = we_q;
    port_d        = port_q;
    bank_z_d      = bank_z;
    bank_reg_no_d = bank_reg_no;
    bank_ld_d     = 1'b0;
    bank_t_d      = 1'b0;
    a_rdata_d     = a_rdata;
    b_rdata_d     = b_rdata;
    a_done_d      = 1'b0;
    b_done_d      = 1'b0;
`ifdef REGBANK_ARB_R0_PROTECT_EN
    b_err_d       = 1'b0;
`endif
    if (A_PRIO != 0) grant_b = b_req && !a_req;
    else             grant_b = b_req && (!a_req || rr_q);
    sel_we    = grant_b ? b_we    : a_we;
    sel_addr  = grant_b ? b_addr  : a_addr;
    sel_wdata = grant_b ? b_wdata : a_wdata;

    unique case (state_q)
      S_IDLE: begin
        if (a_req || b_req) begin
          rr_d   = !grant_b;
          we_d   = sel_we;
          port_d = grant_b;
`ifdef REGBANK_ARB_R0_PROTECT_EN
          if (grant_b && sel_we && (sel_addr == '0)) begin
            state_d  = S_DONE;
            b_done_d = 1'b1;
            b_err_d  = 1'b1;
          end else
`endif
          begin
            state_d       = S_XFER;
            bank_reg_no_d = sel_addr;
            bank_ld_d     = sel_we;
            bank_t_d      = !sel_we;
            if (sel_we) bank_z_d = sel_wdata;
          end
        end
      end
      S_XFER: begin
        state_d = S_DONE;
        if (!we_q) begin
          if (port_q) b_rdata_d = bank_x;
          else        a_rdata_d = bank_x;
        end
        if (port_q) b_done_d = 1'b1;
        else        a_done_d = 1'b1;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

endmodule

// File: tb/tb_reg_bank_access_arbiter.sv
// Directed bench: round-robin instance plus a port-A-priority instance, each with a small bank model.
module tb_reg_bank_access_arbiter;

  localparam int unsigned DW = 16;
  localparam int unsigned AW = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Round-robin instance
  logic          a_req, a_we, b_req, b_we;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_wdata, b_wdata;
  logic [DW-1:0] a_rdata, b_rdata, bank_z, bank_x;
  logic          a_done, b_done, b_err, bank_ld, bank_t, busy;
  logic [AW-1:0] bank_reg_no;
  logic [DW-1:0] mem [8];

  // Port-A-priority instance
  logic          p_a_req, p_b_req;
  logic [DW-1:0] p_a_rdata, p_b_rdata, p_bank_z, p_bank_x;
  logic          p_a_done, p_b_done, p_b_err, p_bank_ld, p_bank_t, p_busy;
  logic [AW-1:0] p_bank_reg_no;
  logic [DW-1:0] p_mem [8];

  reg_bank_access_arbiter #(.DW(DW), .AW(AW), .A_PRIO(0)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_rdata(a_rdata), .a_done(a_done),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_rdata(b_rdata), .b_done(b_done), .b_err(b_err),
    .bank_z(bank_z), .bank_reg_no(bank_reg_no), .bank_ld(bank_ld), .bank_t(bank_t),
    .bank_x(bank_x), .busy(busy)
  );

  reg_bank_access_arbiter #(.DW(DW), .AW(AW), .A_PRIO(1)) dut_p (
    .clk(clk), .rst_n(rst_n),
    .a_req(p_a_req), .a_we(1'b0), .a_addr(3'd1), .a_wdata(16'h0000),
    .a_rdata(p_a_rdata), .a_done(p_a_done),
    .b_req(p_b_req), .b_we(1'b0), .b_addr(3'd2), .b_wdata(16'h0000),
    .b_rdata(p_b_rdata), .b_done(p_b_done), .b_err(p_b_err),
    .bank_z(p_bank_z), .bank_reg_no(p_bank_reg_no), .bank_ld(p_bank_ld), .bank_t(p_bank_t),
    .bank_x(p_bank_x), .busy(p_busy)
  );

  // Bank models: load on ld_reg, read port always shows the addressed word
  initial for (int i = 0; i < 8; i++) begin mem[i] = '0; p_mem[i] = '0; end
  always @(posedge clk) if (bank_ld)   mem[bank_reg_no]     <= bank_z;
  always @(posedge clk) if (p_bank_ld) p_mem[p_bank_reg_no] <= p_bank_z;
  assign bank_x   = mem[bank_reg_no];
  assign p_bank_x = p_mem[p_bank_reg_no];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt_a, cnt_b;
    rst_n = 1'b0;
    a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0;
    b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0;
    p_a_req = 0; p_b_req = 0;
    step(); step();

    // Reset state
    check("rst_busy", busy, 0);
    check("rst_ld", bank_ld, 0);
    check("rst_t", bank_t, 0);
    check("rst_a_done", a_done, 0);
    check("rst_b_done", b_done, 0);
    check("rst_a_rdata", a_rdata, 0);
    check("rst_b_err", b_err, 0);
    rst_n = 1'b1;
    step();

    // A write R5=BEEF, then A read R5
    a_req = 1; a_we = 1; a_addr = 3'd5; a_wdata = 16'hBEEF;
    step();
    check("wr5_ld", bank_ld, 1);
    check("wr5_t", bank_t, 0);
    check("wr5_regno", bank_reg_no, 5);
    check("wr5_z", bank_z, 16'hBEEF);
    check("wr5_busy", busy, 1);
    check("wr5_nodone", a_done, 0);
    step();
    check("wr5_done", a_done, 1);
    check("wr5_ld_off", bank_ld, 0);
    a_req = 0;
    step();
    check("wr5_done_off", a_done, 0);
    check("wr5_idle", busy, 0);
    check("wr5_mem", mem[5], 16'hBEEF);
    a_req = 1; a_we = 0;
    step();
    check("rd5_t", bank_t, 1);
    check("rd5_ld", bank_ld, 0);
    check("rd5_regno", bank_reg_no, 5);
    step();
    check("rd5_done", a_done, 1);
    check("rd5_data", a_rdata, 16'hBEEF);
    a_req = 0;
    step();

    // Reset mid-XFER of an A write to R3
    a_req = 1; a_we = 1; a_addr = 3'd3; a_wdata = 16'h5555;
    step();
    check("wr3_ld", bank_ld, 1);
    rst_n = 1'b0;
    #1;
    check("abort_ld", bank_ld, 0);
    check("abort_busy", busy, 0);
    a_req = 0;
    step();
    check("abort_nodone", a_done, 0);
    check("abort_mem3", mem[3], 16'h0000);
    rst_n = 1'b1;
    step();

    // Round-robin: simultaneous requests, pointer at A
    a_req = 1; a_we = 0; a_addr = 3'd5;
    b_req = 1; b_we = 1; b_addr = 3'd2; b_wdata = 16'h0B0B;
    step();
    check("rr1_xfer_a", bank_reg_no, 5);
    step();
    check("rr1_a_done", a_done, 1);
    check("rr1_b_wait", b_done, 0);
    check("rr1_a_rdata", a_rdata, 16'hBEEF);
    step();
    check("rr1_idle", busy, 0);
    step();   // A still requesting: both compete, pointer now at B
    check("rr2_xfer_b_ld", bank_ld, 1);
    check("rr2_xfer_b_reg", bank_reg_no, 2);
    step();
    check("rr2_b_done", b_done, 1);
    check("rr2_a_wait", a_done, 0);
    check("rr2_b_err", b_err, 0);
    b_req = 0;
    step();
    step();
    check("rr3_xfer_a", bank_reg_no, 5);
    step();
    check("rr3_a_done", a_done, 1);
    check("rr3_mem2", mem[2], 16'h0B0B);
    a_req = 0;
    step();

    // Port-B write to R0 with a known old value
    a_req = 1; a_we = 1; a_addr = 3'd0; a_wdata = 16'h00AA;
    step(); step();
    check("wr0_a_done", a_done, 1);
    a_req = 0;
    step();
    b_req = 1; b_we = 1; b_addr = 3'd0; b_wdata = 16'h1234;
    step();
`ifdef REGBANK_ARB_R0_PROTECT_EN
    check("prot_ld", bank_ld, 0);
    check("prot_b_done", b_done, 1);
    check("prot_b_err", b_err, 1);
    b_req = 0;
    step();
    check("prot_b_done_off", b_done, 0);
    check("prot_b_err_off", b_err, 0);
`else
    check("unprot_ld", bank_ld, 1);
    check("unprot_b_err_x", b_err, 0);
    step();
    check("unprot_b_done", b_done, 1);
    check("unprot_b_err", b_err, 0);
    b_req = 0;
    step();
`endif
    a_req = 1; a_we = 0; a_addr = 3'd0;
    step(); step();
    check("rd0_done", a_done, 1);
`ifdef REGBANK_ARB_R0_PROTECT_EN
    check("rd0_data", a_rdata, 16'h00AA);
`else
    check("rd0_data", a_rdata, 16'h1234);
`endif
    a_req = 0;
    step();

    // B read R7 held without dropping after done: three accesses in nine sampling edges
    a_req = 1; a_we = 1; a_addr = 3'd7; a_wdata = 16'h7777;
    step(); step();
    a_req = 0;
    step();
    b_req = 1; b_we = 0; b_addr = 3'd7;
    cnt_b = 0;
    for (int i = 0; i < 9; i++) begin
      step();
      cnt_b += int'(b_done);
    end
    b_req = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      cnt_b += int'(b_done);
    end
    check("held_b_count", 32'(cnt_b), 3);
    check("held_b_rdata", b_rdata, 16'h7777);
    check("held_idle", busy, 0);

    // A_PRIO=1 instance: both requesting continuously, only A is served
    p_a_req = 1; p_b_req = 1;
    cnt_a = 0; cnt_b = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      cnt_a += int'(p_a_done);
      cnt_b += int'(p_b_done);
      n_assert++;
      assert (!(p_bank_ld && p_bank_t)) else begin
        n_fail++;
        $error("FAIL prio_ld_t_excl: observed=1 expected=0");
      end
    end
    p_a_req = 0; p_b_req = 0;
    check("prio_a_count", 32'(cnt_a), 4);
    check("prio_b_count", 32'(cnt_b), 0);
    check("prio_b_err", p_b_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
